// File: rtl/debug_trace_serializer_if.sv
// debug_trace_serializer_if: commit-trace record type plus the bus bundle between
// the commit-side debug capture logic and the serializer.
//   debug_bus1/debug_bus2 : older/younger committed records of one cycle
//   trace_stall           : commit must not retire this cycle
//   trace_overflow        : sticky, a valid record was dropped
//   debug_wb_*            : single-record writeback trace towards the SoC pins
//   debug_commit_cnt      : records emitted since reset
package debug_trace_pkg;
    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  dest;
        logic        phy_dest;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } debug_bus_t;
endpackage

interface debug_trace_serializer_if;
    import debug_trace_pkg::*;
    debug_bus_t  debug_bus1;
    debug_bus_t  debug_bus2;
    logic        trace_stall;
    logic        trace_overflow;
    logic        debug_wb_valid;
    logic [31:0] debug_wb_pc;
    logic [3:0]  debug_wb_rf_wen;
    logic [4:0]  debug_wb_rf_wnum;
    logic [31:0] debug_wb_rf_wdata;
    logic [31:0] debug_commit_cnt;
    modport master (
        output debug_bus1, debug_bus2,
        input  trace_stall, trace_overflow, debug_wb_valid, debug_wb_pc,
               debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata, debug_commit_cnt
    );
    modport slave (
        input  debug_bus1, debug_bus2,
        output trace_stall, trace_overflow, debug_wb_valid, debug_wb_pc,
               debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata, debug_commit_cnt
    );
endinterface

// File: rtl/debug_trace_serializer.sv
// debug_trace_serializer: folds the two-wide commit trace into a one-record-per-cycle
// writeback trace through a DEPTH-entry FIFO, preserving program order.
//   clk   : core clock
//   reset : asynchronous active-high, clears all state
//   bus   : slave side of debug_trace_serializer_if (commit records in, trace out)
module debug_trace_serializer
    import debug_trace_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input logic                      clk,
    input logic                      reset,
    debug_trace_serializer_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [31:0] pc;
        logic [3:0]  wen;
        logic [4:0]  wnum;
        logic [31:0] wdata;
    } entry_t;

    entry_t        mem [DEPTH];
    entry_t        e1, e2, head;
    logic [AW-1:0] wp, rp;
    logic [AW:0]   count, room;
    logic          pop, v1, v2, put1, put2, drop;

    // Writes to r0 are not architectural, so they carry no byte enables.
    function automatic entry_t pack(debug_bus_t b);
        return '{pc: b.pc, wen: (b.dest != 5'd0) ? b.wstrb : 4'b0, wnum: b.dest, wdata: b.wdata};
    endfunction

    always_comb begin
        v1 = bus.debug_bus1.valid;
        v2 = bus.debug_bus2.valid;
        pop = count != '0;
        head = mem[rp];
        // Free slots once this cycle's pop has left; pushes never bypass the head.
        room = (AW+1)'(DEPTH) - count + (AW+1)'(pop);
        // First slot takes the oldest valid record, so bus2 is what gets dropped.
        e1 = v1 ? pack(bus.debug_bus1) : pack(bus.debug_bus2);
        e2 = pack(bus.debug_bus2);
        put1 = (v1 | v2) && room != '0;
        put2 = v1 && v2 && room > (AW+1)'(1);
        drop = ((v1 | v2) && !put1) || (v1 && v2 && !put2);
        // Leaves room for the pair already committed when the stall is seen.
        bus.trace_stall = count > (AW+1)'(DEPTH - 4);
    end

    always_ff @(posedge clk) begin
        if (put1) mem[wp] <= e1;
        if (put2) mem[wp + AW'(1)] <= e2;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wp                    <= '0;
            rp                    <= '0;
            count                 <= '0;
            bus.trace_overflow    <= 1'b0;
            bus.debug_wb_valid    <= 1'b0;
            bus.debug_wb_pc       <= '0;
            bus.debug_wb_rf_wen   <= '0;
            bus.debug_wb_rf_wnum  <= '0;
            bus.debug_wb_rf_wdata <= '0;
            bus.debug_commit_cnt  <= '0;
        end else begin
            wp    <= wp + AW'(put1) + AW'(put2);
            count <= count + (AW+1)'(put1) + (AW+1)'(put2) - (AW+1)'(pop);
            if (drop) bus.trace_overflow <= 1'b1;
            bus.debug_wb_valid <= pop;
            if (pop) begin
                rp                    <= rp + AW'(1);
                bus.debug_wb_pc       <= head.pc;
                bus.debug_wb_rf_wen   <= head.wen;
                bus.debug_wb_rf_wnum  <= head.wnum;
                bus.debug_wb_rf_wdata <= head.wdata;
                bus.debug_commit_cnt  <= bus.debug_commit_cnt + 32'd1;
            end else begin
                bus.debug_wb_rf_wen   <= '0;
            end
        end
    end
endmodule

// File: tb/tb_debug_trace_serializer.sv
// tb_debug_trace_serializer: scoreboard bench for debug_trace_serializer.
module tb_debug_trace_serializer;
    import debug_trace_pkg::*;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;

    debug_trace_serializer_if tif();
    debug_trace_serializer #(.DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .bus(tif.slave));

    always #5 clk = ~clk;

    logic [72:0] q[$];
    logic        exp_valid = 1'b0;
    logic        exp_ovf = 1'b0;
    logic [31:0] exp_cnt = '0;

    function automatic debug_bus_t rec(logic v, logic [31:0] pc, logic [4:0] d, logic [3:0] s, logic [31:0] w);
        debug_bus_t b;
        b.valid = v; b.pc = pc; b.dest = d; b.phy_dest = pc[2]; b.wstrb = s; b.wdata = w;
        return b;
    endfunction

    function automatic logic [72:0] mk(debug_bus_t b);
        return {b.pc, (b.dest != 5'd0) ? b.wstrb : 4'b0, b.dest, b.wdata};
    endfunction

    // Reference FIFO: q holds records accepted but not yet seen on the output.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            q.delete();
            exp_valid = 1'b0;
            exp_ovf = 1'b0;
            exp_cnt = '0;
        end else begin
            int c, room;
            c = q.size();
            room = DEPTH - c + ((c != 0) ? 1 : 0);
            if (tif.debug_bus1.valid) begin
                if (room > 0) begin q.push_back(mk(tif.debug_bus1)); room--; end
                else exp_ovf = 1'b1;
            end
            if (tif.debug_bus2.valid) begin
                if (room > 0) begin q.push_back(mk(tif.debug_bus2)); room--; end
                else exp_ovf = 1'b1;
            end
            exp_valid = c != 0;
            if (c != 0) exp_cnt = exp_cnt + 32'd1;
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            logic [72:0] e;
            logic [72:0] got;
            e = '0;
            if (exp_valid) e = q.pop_front();
            got = {tif.debug_wb_pc, tif.debug_wb_rf_wen, tif.debug_wb_rf_wnum, tif.debug_wb_rf_wdata};
            total++;
            if (tif.debug_wb_valid !== exp_valid) begin
                bad++; $display("FAIL sb_valid t=%0t got=%b want=%b", $time, tif.debug_wb_valid, exp_valid);
            end
            total++;
            if (exp_valid && got !== e) begin
                bad++; $display("FAIL sb_record t=%0t got=%h want=%h", $time, got, e);
            end else if (!exp_valid && tif.debug_wb_rf_wen !== 4'b0) begin
                bad++; $display("FAIL sb_idle_wen t=%0t got=%h want=0", $time, tif.debug_wb_rf_wen);
            end
            total++;
            if (tif.trace_stall !== (q.size() > DEPTH - 4)) begin
                bad++; $display("FAIL sb_stall t=%0t got=%b want=%b", $time, tif.trace_stall, q.size() > DEPTH - 4);
            end
            total++;
            if (tif.trace_overflow !== exp_ovf) begin
                bad++; $display("FAIL sb_overflow t=%0t got=%b want=%b", $time, tif.trace_overflow, exp_ovf);
            end
            total++;
            if (tif.debug_commit_cnt !== exp_cnt) begin
                bad++; $display("FAIL sb_cnt t=%0t got=%0d want=%0d", $time, tif.debug_commit_cnt, exp_cnt);
            end
        end
    end

    task automatic idle();
        tif.debug_bus1 = '0;
        tif.debug_bus2 = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic drain(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            idle();
            #1;
            if (q.size() == 0 && !tif.debug_wb_valid) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b1;
        #1;
        total++;
        if ({tif.debug_wb_valid, tif.debug_wb_pc, tif.debug_wb_rf_wen, tif.debug_wb_rf_wnum,
             tif.debug_wb_rf_wdata, tif.debug_commit_cnt, tif.trace_stall, tif.trace_overflow} !== '0) begin
            bad++; $display("FAIL reset_state got valid=%b pc=%h cnt=%0d stall=%b ovf=%b want all 0",
                tif.debug_wb_valid, tif.debug_wb_pc, tif.debug_commit_cnt, tif.trace_stall, tif.trace_overflow);
        end
        do_reset();
    endtask

    task automatic test_single();
        do_reset();
        @(negedge clk);
        tif.debug_bus1 = rec(1'b1, 32'hBFC0_0000, 5'd3, 4'hF, 32'h12);
        @(negedge clk);
        idle();
        @(posedge clk); #1;
        total++;
        if ({tif.debug_wb_valid, tif.debug_wb_pc, tif.debug_wb_rf_wen, tif.debug_wb_rf_wnum, tif.debug_wb_rf_wdata}
            !== {1'b1, 32'hBFC0_0000, 4'hF, 5'd3, 32'h12}) begin
            bad++; $display("FAIL single_out got v=%b pc=%h wen=%h wnum=%0d wdata=%h want 1 bfc00000 f 3 12",
                tif.debug_wb_valid, tif.debug_wb_pc, tif.debug_wb_rf_wen, tif.debug_wb_rf_wnum, tif.debug_wb_rf_wdata);
        end
        @(posedge clk); #1;
        total++;
        if ({tif.debug_wb_valid, tif.debug_wb_rf_wen, tif.debug_commit_cnt} !== {1'b0, 4'h0, 32'd1}) begin
            bad++; $display("FAIL single_after got v=%b wen=%h cnt=%0d want 0 0 1",
                tif.debug_wb_valid, tif.debug_wb_rf_wen, tif.debug_commit_cnt);
        end
    endtask

    task automatic test_pairs();
        bit ok;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tif.debug_bus1 = rec(1'b1, 32'h100 + 32'(8*i), 5'(i + 1), 4'hF, 32'hA0 + 32'(i));
            tif.debug_bus2 = rec(1'b1, 32'h104 + 32'(8*i), 5'(i + 9), 4'h3, 32'hB0 + 32'(i));
        end
        drain(ok);
        total++;
        if (!ok) begin bad++; $display("FAIL pairs_drain got timeout want empty"); end
        total++;
        if (tif.debug_commit_cnt !== 32'd6) begin
            bad++; $display("FAIL pairs_cnt got=%0d want=6", tif.debug_commit_cnt);
        end
    endtask

    task automatic test_bus2_only();
        bit seen;
        do_reset();
        @(negedge clk);
        tif.debug_bus2 = rec(1'b1, 32'h200, 5'd0, 4'hF, 32'hDEAD);
        @(negedge clk);
        idle();
        seen = 1'b0;
        for (int i = 0; i < 5 && !seen; i++) begin
            @(posedge clk); #1;
            if (tif.debug_wb_valid) begin
                seen = 1'b1;
                total++;
                if ({tif.debug_wb_pc, tif.debug_wb_rf_wen} !== {32'h200, 4'h0}) begin
                    bad++; $display("FAIL bus2_only got pc=%h wen=%h want 200 0", tif.debug_wb_pc, tif.debug_wb_rf_wen);
                end
            end
        end
        total++;
        if (!seen) begin bad++; $display("FAIL bus2_only_seen got none want one record"); end
    endtask

    task automatic test_overflow();
        bit ok;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            tif.debug_bus1 = rec(1'b1, 32'h1000 + 32'(8*i), 5'd4, 4'hF, 32'(i));
            tif.debug_bus2 = rec(1'b1, 32'h1004 + 32'(8*i), 5'd5, 4'hC, 32'(i) ^ 32'hFFFF);
        end
        drain(ok);
        total++;
        if (!ok) begin bad++; $display("FAIL ovf_drain got timeout want empty"); end
        total++;
        if (tif.trace_overflow !== 1'b1) begin
            bad++; $display("FAIL ovf_sticky got=%b want=1", tif.trace_overflow);
        end
    endtask

    task automatic test_stall_random();
        bit ok;
        int pushes;
        logic [31:0] pc;
        do_reset();
        pushes = 0;
        pc = 32'h8000_0000;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            idle();
            if (!tif.trace_stall) begin
                if ($urandom_range(0, 3) != 0) begin
                    tif.debug_bus1 = rec(1'b1, pc, 5'($urandom_range(0, 31)), 4'($urandom), $urandom);
                    pc += 4; pushes++;
                end
                if ($urandom_range(0, 2) != 0) begin
                    tif.debug_bus2 = rec(1'b1, pc, 5'($urandom_range(0, 31)), 4'($urandom), $urandom);
                    pc += 4; pushes++;
                end
            end
        end
        drain(ok);
        total++;
        if (!ok) begin bad++; $display("FAIL rand_drain got timeout want empty"); end
        total++;
        if (tif.trace_overflow !== 1'b0) begin
            bad++; $display("FAIL rand_overflow got=%b want=0", tif.trace_overflow);
        end
        total++;
        if (tif.debug_commit_cnt !== 32'(pushes)) begin
            bad++; $display("FAIL rand_cnt got=%0d want=%0d", tif.debug_commit_cnt, pushes);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tif.debug_bus1 = rec(1'b1, 32'h300 + 32'(8*i), 5'd7, 4'hF, 32'h55);
            tif.debug_bus2 = rec(1'b1, 32'h304 + 32'(8*i), 5'd8, 4'hF, 32'h66);
        end
        @(posedge clk); #2;
        idle();
        total++;
        if (tif.debug_wb_valid !== 1'b1) begin
            bad++; $display("FAIL mid_busy got valid=%b want=1", tif.debug_wb_valid);
        end
        reset = 1'b1;
        #1;
        total++;
        if ({tif.debug_wb_valid, tif.debug_wb_pc, tif.debug_wb_rf_wen, tif.debug_wb_rf_wnum,
             tif.debug_wb_rf_wdata, tif.debug_commit_cnt, tif.trace_stall} !== '0) begin
            bad++; $display("FAIL mid_reset got valid=%b pc=%h cnt=%0d want all 0",
                tif.debug_wb_valid, tif.debug_wb_pc, tif.debug_commit_cnt);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        tif.debug_bus1 = rec(1'b1, 32'h400, 5'd2, 4'h1, 32'h77);
        @(negedge clk);
        idle();
        @(posedge clk); #1;
        total++;
        if ({tif.debug_wb_valid, tif.debug_wb_pc, tif.debug_commit_cnt} !== {1'b1, 32'h400, 32'd1}) begin
            bad++; $display("FAIL mid_after got v=%b pc=%h cnt=%0d want 1 400 1",
                tif.debug_wb_valid, tif.debug_wb_pc, tif.debug_commit_cnt);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single();
        test_pairs();
        test_bus2_only();
        test_overflow();
        test_stall_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
